// File: rtl/serial_adder_sched.sv
// Bit-serial add scheduler: two requesters share one full-adder cell.
// Round-robin grant, operands fed LSB-first one bit per clock, carry kept
// in a register, registered sum/carry-out/requester id on a valid/ready port.

// One-bit full adder cell shared by both requesters.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_prio;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_id;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sacc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_res_id;

  logic             w_gnt;
  logic             w_idle;
  logic             w_accept;
  logic             w_last_bit;
  logic             w_fa_sum;
  logic             w_fa_cout;
  logic [WIDTH-1:0] w_sacc_nxt;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic             w_op_cin;

  // Round-robin grant: a lone requester wins, otherwise the one holding priority.
  always_comb begin
    w_gnt = 1'b0;
    if (req0_valid && req1_valid)
      w_gnt = r_prio;
    else if (req1_valid)
      w_gnt = 1'b1;
  end

  // Readiness is only offered from IDLE and never while reset is asserted.
  assign w_idle     = (r_state == S_IDLE) && !rst;
  assign req0_ready = w_idle && req0_valid && !w_gnt;
  assign req1_ready = w_idle && req1_valid && w_gnt;
  assign w_accept   = req0_ready || req1_ready;

  assign w_op_a   = w_gnt ? req1_a   : req0_a;
  assign w_op_b   = w_gnt ? req1_b   : req0_b;
  assign w_op_cin = w_gnt ? req1_cin : req0_cin;

  full_adder u_fa (
    .a  (r_sa[0]),
    .b  (r_sb[0]),
    .ci (r_carry),
    .s  (w_fa_sum),
    .co (w_fa_cout)
  );

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign w_sacc_nxt = {w_fa_sum, r_sacc[WIDTH-1:1]};
  assign w_last_bit = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));

  // Next-state logic of the IDLE/RUN/DONE sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_state_nxt = S_RUN;
      S_RUN:   if (w_last_bit) w_state_nxt = S_DONE;
      S_DONE:  if (res_ready)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Control and result registers: loaded on accept, advanced during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio   <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_id     <= 1'b0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_res_id <= 1'b0;
    end else if (w_accept) begin
      r_carry <= w_op_cin;
      r_cnt   <= '0;
      r_id    <= w_gnt;
      r_prio  <= ~w_gnt;
    end else if (r_state == S_RUN) begin
      r_carry <= w_fa_cout;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last_bit) begin
        r_sum    <= w_sacc_nxt;
        r_cout   <= w_fa_cout;
        r_res_id <= r_id;
      end
    end
  end

  // Operand shift registers and sum accumulator; contents are don't-care in IDLE.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sa <= w_op_a;
      r_sb <= w_op_b;
    end else if (r_state == S_RUN) begin
      r_sa   <= r_sa >> 1;
      r_sb   <= r_sb >> 1;
      r_sacc <= w_sacc_nxt;
    end
  end

  assign res_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign res_sum   = r_sum;
  assign res_cout  = r_cout;
  assign res_id    = r_res_id;

endmodule

// File: tb/tb_serial_adder_sched.sv
// Bench for serial_adder_sched: directed scenarios plus random traffic,
// checked each cycle against a transaction-level model of the scheduler.
module tb_serial_adder_sched;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             req0_cin, req1_cin;
  logic             req0_ready, req1_ready;
  logic             res_valid, res_ready;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout, res_id, busy;

  always #5 clk = ~clk;

  serial_adder_sched #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_cout   (res_cout),
    .res_id     (res_id),
    .busy       (busy)
  );

  typedef struct {
    int             id;
    logic [WIDTH-1:0] sum;
    logic           cout;
    int             acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rr = 0;          // requester whose turn it is when both ask
  int   contention = 0;
  int   last_acc = -1;
  int   acc_count = 0;
  int   last_acc_id = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(input int who, input logic v, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin);
    if (who == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_cin = cin;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_cin = cin;
    end
  endtask

  task automatic scramble(input int who);
    set_req(who, (who == 0) ? req0_valid : req1_valid, WIDTH'($urandom), WIDTH'($urandom),
            1'($urandom));
  endtask

  // Sample just before the next edge, check against the model, then advance one clock.
  task automatic tick();
    exp_t           e;
    logic [WIDTH:0] s;
    logic           x0, x1;
    #1;
    if (rst) begin
      check_eq("rdy_in_rst", 32'({req1_ready, req0_ready}), 32'd0);
      q.delete();
      rr = 0;
      last_acc = -1;
    end else if (q.size() == 0) begin
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_vld", 32'(res_valid), 32'd0);
      x0 = req0_valid && (!req1_valid || rr == 0);
      x1 = req1_valid && (!req0_valid || rr == 1);
      check_eq("rdy0", 32'(req0_ready), 32'(x0));
      check_eq("rdy1", 32'(req1_ready), 32'(x1));
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        e.id = (req1_valid && req1_ready) ? 1 : 0;
        if (e.id == 1)
          s = {1'b0, req1_a} + {1'b0, req1_b} + {{WIDTH{1'b0}}, req1_cin};
        else
          s = {1'b0, req0_a} + {1'b0, req0_b} + {{WIDTH{1'b0}}, req0_cin};
        e.sum  = s[WIDTH-1:0];
        e.cout = s[WIDTH];
        e.acc  = cyc;
        if (contention != 0 && last_acc >= 0)
          check_eq("period", 32'(cyc - last_acc), 32'(WIDTH + 2));
        last_acc    = cyc;
        last_acc_id = e.id;
        acc_count++;
        rr = 1 - e.id;
        q.push_back(e);
      end
    end else begin
      check_eq("busy_rdy", 32'({req1_ready, req0_ready}), 32'd0);
      check_eq("busy", 32'(busy), 32'd1);
      check_eq("res_vld", 32'(res_valid), 32'((cyc - q[0].acc) >= WIDTH + 1));
      if (res_valid) begin
        check_eq("res_sum", 32'(res_sum), 32'(q[0].sum));
        check_eq("res_cout", 32'(res_cout), 32'(q[0].cout));
        check_eq("res_id", 32'(res_id), 32'(q[0].id));
        if (res_ready) void'(q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int n;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res_ready  = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 40) begin tick(); n++; end
    check_eq("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic run_op(input string tag, input int who, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic cin,
                        input logic [WIDTH-1:0] xsum, input logic xcout);
    int n;
    set_req(who, 1'b1, a, b, cin);
    set_req(1 - who, 1'b0, '0, '0, 1'b0);
    res_ready = 1'b1;
    n = 0;
    while (q.size() == 0 && n < 30) begin tick(); n++; end
    check_eq({tag, "_acc"}, 32'(q.size()), 32'd1);
    set_req(who, 1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    n = 0;
    while (q.size() != 0 && n < 40) begin tick(); n++; end
    check_eq({tag, "_done"}, 32'(q.size()), 32'd0);
    check_eq({tag, "_sum"}, 32'(res_sum), 32'(xsum));
    check_eq({tag, "_cout"}, 32'(res_cout), 32'(xcout));
    check_eq({tag, "_id"}, 32'(res_id), 32'(who));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, n0, pre;
    int ids[$];
    logic [WIDTH-1:0] snap_sum;
    logic snap_cout, snap_id;

    // Reset with requester 0 already asking.
    rst = 1'b1;
    res_ready = 1'b0;
    set_req(0, 1'b1, 8'h5A, 8'h3C, 1'b0);
    set_req(1, 1'b0, '0, '0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_vld", 32'(res_valid), 32'd0);
    check_eq("rst_sum", 32'(res_sum), 32'd0);
    check_eq("rst_cout", 32'(res_cout), 32'd0);
    check_eq("rst_id", 32'(res_id), 32'd0);
    check_eq("rst_rdy0", 32'(req0_ready), 32'd1);

    // Single op and carry corner cases.
    run_op("single", 0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    run_op("c_ff01", 1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("c_ffff", 1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_op("c_0001", 1, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

    // Contention from reset: both always valid, consumer always ready.
    rst = 1'b1;
    set_req(0, 1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    set_req(1, 1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    res_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    contention = 1;
    n0 = acc_count;
    for (int i = 0; i < 60; i++) begin
      pre = acc_count;
      tick();
      if (acc_count != pre) begin
        ids.push_back(last_acc_id);
        scramble(last_acc_id);
      end
    end
    contention = 0;
    check_eq("cont_n", 32'(acc_count - n0), 32'd6);
    for (int k = 0; k < ids.size(); k++)
      check_eq("cont_seq", 32'(ids[k]), 32'(k % 2));
    drain();

    // Backpressure in DONE with requester 1 waiting.
    res_ready = 1'b0;
    set_req(0, 1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    n = 0;
    while (q.size() == 0 && n < 30) begin tick(); n++; end
    check_eq("bp_acc", 32'(q.size()), 32'd1);
    req0_valid = 1'b0;
    set_req(1, 1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    n = 0;
    while (!res_valid && n < 30) begin tick(); n++; end
    check_eq("bp_vld", 32'(res_valid), 32'd1);
    snap_sum = res_sum; snap_cout = res_cout; snap_id = res_id;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_hold_vld", 32'(res_valid), 32'd1);
      check_eq("bp_hold", 32'({res_id, res_cout, res_sum}), 32'({snap_id, snap_cout, snap_sum}));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n0 = acc_count;
    tick();
    check_eq("bp_next", 32'(acc_count - n0), 32'd1);
    check_eq("bp_next_id", 32'(last_acc_id), 32'd1);
    drain();

    // Reset after three bits of a requester-0 operation.
    res_ready = 1'b0;
    set_req(0, 1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    n = 0;
    while (q.size() == 0 && n < 30) begin tick(); n++; end
    check_eq("mr_acc_id", 32'(last_acc_id), 32'd0);
    req0_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    res_ready = 1'b1;
    set_req(0, 1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    set_req(1, 1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    tick();
    rst = 1'b0;
    #1;
    check_eq("mr_busy", 32'(busy), 32'd0);
    check_eq("mr_vld", 32'(res_valid), 32'd0);
    n0 = acc_count;
    tick();
    check_eq("mr_gnt_n", 32'(acc_count - n0), 32'd1);
    check_eq("mr_gnt_id", 32'(last_acc_id), 32'd0);
    drain();

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      req0_valid = ($urandom_range(0, 99) < 50);
      req1_valid = ($urandom_range(0, 99) < 50);
      scramble(0);
      scramble(1);
      res_ready = ($urandom_range(0, 99) < 60);
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
